bullet_line_scanner: RTL

Per-scanline object scanner for the VGA path: during horizontal blanking it walks the bullet RAM sequentially, collects the objects that intersect the next scanline into a double-buffered line list, and during the active region it reports per-pixel hit and colour to the colour mux. It sits between the bullet RAM read port and the final colour selection. It replaces single-cycle whole-table bullet checks with a bounded, pipelined scan that is parametrised in object count, object size and per-line capacity.

---
 rtl/bullet_line_scanner.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/bullet_line_scanner.sv
// bullet_line_scanner: per-scanline bullet scan into a double-buffered line list,
// plus a registered per-pixel hit/colour lookup against the front list.
module bullet_line_scanner #(
    parameter int MAX_OBJ    = 64,
    parameter int ADDR_W     = 6,
    parameter int OBJ_SIZE   = 8,
    parameter int LINE_SLOTS = 8,
    parameter int X_W        = 10,
    parameter int Y_W        = 10
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              line_start,
    input  logic [Y_W-1:0]                    target_y,
    input  logic                              frame_start,
    input  logic [X_W-1:0]                    x,
    input  logic                              active,
    output logic                              rd_en,
    output logic [ADDR_W-1:0]                 rd_addr,
    input  logic [31:0]                       rd_data,
    output logic                              pix_hit,
    output logic [3:0]                        pix_color,
    output logic                              busy,
    output logic [$clog2(LINE_SLOTS+1)-1:0]   line_count,
    output logic                              overflow
);
    localparam int CW = $clog2(LINE_SLOTS + 1);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MAX_OBJ - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t state_q, state_d;
    logic [Y_W-1:0] ty_q, ty_d;
    logic rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic dv_q, dv_d;
    logic [LINE_SLOTS-1:0][X_W-1:0] bk_x_q, bk_x_d, fr_x_q, fr_x_d;
    logic [LINE_SLOTS-1:0][3:0] bk_c_q, bk_c_d, fr_c_q, fr_c_d;
    logic [LINE_SLOTS-1:0] bk_v_q, bk_v_d, fr_v_q, fr_v_d;
    logic [CW-1:0] bk_n_q, bk_n_d, fr_n_q, fr_n_d;
    logic ovf_q, ovf_d;
    logic pix_hit_q, pix_hit_d;
    logic [3:0] pix_col_q, pix_col_d;

    logic [X_W-1:0] obj_x;
    logic [Y_W-1:0] obj_y;
    logic [3:0] obj_c;
    logic obj_a, y_hit, last, abort, drop, swap;
    logic [LINE_SLOTS-1:0] px_hit;
    logic [3:0] px_col;
    logic unused_bits;

    assign obj_x = rd_data[22 +: X_W];
    assign obj_y = rd_data[12 +: Y_W];
    assign obj_c = rd_data[11:8];
    assign obj_a = rd_data[5];
    assign unused_bits = ^{rd_data[7:6], rd_data[4:0]};
    // Widened compare so by+OBJ_SIZE cannot wrap past the top of the field.
    assign y_hit = obj_a && ({1'b0, obj_y} <= {1'b0, ty_q})
                 && ({1'b0, ty_q} < {1'b0, obj_y} + (Y_W+1)'(OBJ_SIZE));
    assign last  = rd_addr_q == LAST;
    assign abort = line_start && state_q != IDLE;
    assign swap  = state_q == DRAIN && !line_start;

    always_comb begin
        state_d   = line_start ? SCAN
                  : (state_q == SCAN && last) ? DRAIN
                  : (state_q == DRAIN) ? IDLE : state_q;
        rd_en_d   = line_start || (state_q == SCAN && !last);
        rd_addr_d = line_start ? '0
                  : (state_q == SCAN && !last) ? rd_addr_q + ADDR_W'(1) : rd_addr_q;
        dv_d      = !line_start && rd_en_q;
        ty_d      = line_start ? target_y : ty_q;
    end

    always_comb begin
        bk_x_d = bk_x_q;
        bk_c_d = bk_c_q;
        bk_v_d = bk_v_q;
        bk_n_d = bk_n_q;
        drop   = 1'b0;
        if (line_start) begin
            bk_v_d = '0;
            bk_n_d = '0;
        end else if (dv_q && y_hit) begin
            if (bk_n_q < CW'(LINE_SLOTS)) begin
                for (int i = 0; i < LINE_SLOTS; i++) begin
                    if (CW'(i) == bk_n_q) begin
                        bk_x_d[i] = obj_x;
                        bk_c_d[i] = obj_c;
                        bk_v_d[i] = 1'b1;
                    end
                end
                bk_n_d = bk_n_q + CW'(1);
            end else begin
                drop = 1'b1;
            end
        end
        // The swap takes the back list including the word evaluated in DRAIN.
        fr_x_d = swap ? bk_x_d : fr_x_q;
        fr_c_d = swap ? bk_c_d : fr_c_q;
        fr_v_d = swap ? bk_v_d : fr_v_q;
        fr_n_d = swap ? bk_n_d : fr_n_q;
        ovf_d  = (abort || drop) ? 1'b1 : frame_start ? 1'b0 : ovf_q;
    end

    always_comb begin
        px_col = '0;
        for (int i = 0; i < LINE_SLOTS; i++)
            px_hit[i] = fr_v_q[i] && ({1'b0, fr_x_q[i]} <= {1'b0, x})
                      && ({1'b0, x} < {1'b0, fr_x_q[i]} + (X_W+1)'(OBJ_SIZE));
        for (int i = LINE_SLOTS - 1; i >= 0; i--)
            if (px_hit[i]) px_col = fr_c_q[i];
        pix_hit_d = (|px_hit) && active;
        pix_col_d = pix_hit_d ? px_col : 4'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ty_q      <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            dv_q      <= 1'b0;
            bk_x_q    <= '0;
            bk_c_q    <= '0;
            bk_v_q    <= '0;
            bk_n_q    <= '0;
            fr_x_q    <= '0;
            fr_c_q    <= '0;
            fr_v_q    <= '0;
            fr_n_q    <= '0;
            ovf_q     <= 1'b0;
            pix_hit_q <= 1'b0;
            pix_col_q <= '0;
        end else begin
            state_q   <= state_d;
            ty_q      <= ty_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            dv_q      <= dv_d;
            bk_x_q    <= bk_x_d;
            bk_c_q    <= bk_c_d;
            bk_v_q    <= bk_v_d;
            bk_n_q    <= bk_n_d;
            fr_x_q    <= fr_x_d;
            fr_c_q    <= fr_c_d;
            fr_v_q    <= fr_v_d;
            fr_n_q    <= fr_n_d;
            ovf_q     <= ovf_d;
            pix_hit_q <= pix_hit_d;
            pix_col_q <= pix_col_d;
        end
    end

    assign rd_en      = rd_en_q;
    assign rd_addr    = rd_addr_q;
    assign pix_hit    = pix_hit_q;
    assign pix_color  = pix_col_q;
    assign busy       = state_q != IDLE;
    assign line_count = fr_n_q;
    assign overflow   = ovf_q;
endmodule
